// File: rtl/ck_io_gpio.sv
// ck_io_gpio
// Register-programmed controller for the Arduino-header ck_io pins.
// Each pin can be a plain GPIO (direction + output data) or be handed to an
// alternate-function peripheral. Pad inputs are synchronised and fed to both
// the DATA_IN register and the peripheral. Rising/falling edges can latch
// sticky status bits that drive a level interrupt.
//
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   reg_wr, reg_rd         register access strobes (one access per cycle)
//   reg_addr[2:0]          word address
//   reg_wdata[31:0]        write data
//   reg_rdata[31:0]        read data, held until the next read
//   reg_ack                one-cycle acknowledge, the cycle after the access
//   io_i/io_o/io_t         pad input / output / tristate (1 = high-Z)
//   alt_o/alt_t            alternate-function peripheral output / tristate
//   alt_i                  synchronised pad input to the peripheral
//   irq                    OR of all IRQ_STATUS bits
//
// Bus handshake: a strobe (reg_wr or reg_rd) high at a rising edge is one
// access. There is no back-pressure; the access always completes at that edge
// and reg_ack is high for exactly the following cycle. If both strobes are
// high, only the write is performed and a single ack is returned.
module ck_io_gpio #(
    parameter int          N_PINS    = 14,
    parameter logic [31:0] DIR_RESET = 32'h0,
    parameter logic [31:0] OUT_RESET = 32'h0,
    parameter logic [31:0] ALT_RESET = 32'h3
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              reg_wr,
    input  logic              reg_rd,
    input  logic [2:0]        reg_addr,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       reg_rdata,
    output logic              reg_ack,
    input  logic [N_PINS-1:0] io_i,
    output logic [N_PINS-1:0] io_o,
    output logic [N_PINS-1:0] io_t,
    input  logic [N_PINS-1:0] alt_o,
    input  logic [N_PINS-1:0] alt_t,
    output logic [N_PINS-1:0] alt_i,
    output logic              irq
);

    localparam logic [2:0] ADDR_DATA_OUT = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_DATA_IN  = 3'd2;
    localparam logic [2:0] ADDR_ALT_SEL  = 3'd3;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd5;
    localparam logic [2:0] ADDR_IRQ_STAT = 3'd6;

    localparam logic [N_PINS-1:0] DIR_RST = DIR_RESET[N_PINS-1:0];
    localparam logic [N_PINS-1:0] OUT_RST = OUT_RESET[N_PINS-1:0];
    localparam logic [N_PINS-1:0] ALT_RST = ALT_RESET[N_PINS-1:0];

    logic [N_PINS-1:0] data_out;
    logic [N_PINS-1:0] dir;
    logic [N_PINS-1:0] alt_sel;
    logic [N_PINS-1:0] rise_en;
    logic [N_PINS-1:0] fall_en;
    logic [N_PINS-1:0] irq_status;
    logic [N_PINS-1:0] s1, s2, s3;

    logic [N_PINS-1:0] wdata_n;
    logic [N_PINS-1:0] rise, fall;
    logic [N_PINS-1:0] set_bits;
    logic [N_PINS-1:0] clr_bits;
    logic [31:0]       rd_word;

    // Only the low N_PINS write-data bits are implemented; the rest are
    // deliberately dropped.
    logic unused_wdata;
    assign unused_wdata = ^reg_wdata;
    assign wdata_n      = reg_wdata[N_PINS-1:0];

    // s2 is the synchronised level; s3 is its one-cycle history.
    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
    assign set_bits = (rise & rise_en) | (fall & fall_en);

    always_comb begin
        clr_bits = '0;
        if (reg_wr && reg_addr == ADDR_IRQ_STAT) begin
            clr_bits = wdata_n;
        end
    end

    // Read mux sees register state before any same-edge update.
    always_comb begin
        rd_word = '0;
        case (reg_addr)
            ADDR_DATA_OUT: rd_word[N_PINS-1:0] = data_out;
            ADDR_DIR:      rd_word[N_PINS-1:0] = dir;
            ADDR_DATA_IN:  rd_word[N_PINS-1:0] = s2;
            ADDR_ALT_SEL:  rd_word[N_PINS-1:0] = alt_sel;
            ADDR_RISE_EN:  rd_word[N_PINS-1:0] = rise_en;
            ADDR_FALL_EN:  rd_word[N_PINS-1:0] = fall_en;
            ADDR_IRQ_STAT: rd_word[N_PINS-1:0] = irq_status;
            default:       rd_word = '0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            data_out   <= OUT_RST;
            dir        <= DIR_RST;
            alt_sel    <= ALT_RST;
            rise_en    <= '0;
            fall_en    <= '0;
            irq_status <= '0;
            s1         <= '0;
            s2         <= '0;
            s3         <= '0;
            reg_rdata  <= '0;
            reg_ack    <= 1'b0;
        end else begin
            s1 <= io_i;
            s2 <= s1;
            s3 <= s2;

            // A new edge wins over a same-cycle W1C clear.
            irq_status <= set_bits | (irq_status & ~clr_bits);

            reg_ack <= reg_wr | reg_rd;

            if (reg_wr) begin
                case (reg_addr)
                    ADDR_DATA_OUT: data_out <= wdata_n;
                    ADDR_DIR:      dir      <= wdata_n;
                    ADDR_ALT_SEL:  alt_sel  <= wdata_n;
                    ADDR_RISE_EN:  rise_en  <= wdata_n;
                    ADDR_FALL_EN:  fall_en  <= wdata_n;
                    default:       ;
                endcase
            end else if (reg_rd) begin
                reg_rdata <= rd_word;
            end
        end
    end

    // Pin mux: alternate function overrides the GPIO registers per pin.
    assign io_o  = (alt_sel & alt_o) | (~alt_sel & data_out);
    assign io_t  = (alt_sel & alt_t) | (~alt_sel & ~dir);
    assign alt_i = s2;
    assign irq   = |irq_status;

endmodule

// File: doc/ck_io_gpio.md
# ck_io_gpio

Parametrised PL-side controller for the Arduino-header `ck_io` pins. It replaces fixed per-pin wiring with register-programmed behaviour:
- per-pin direction and output data;
- per-pin routing to an alternate-function peripheral (e.g. PS UART rx/tx);
- synchronised input readback;
- rising/falling edge capture with a level interrupt.

It sits between the PS register bus bridge and the pad tristate buffers in the top level.

## Interface
Parameters:
- `N_PINS`, 14, number of pins (1..32).
- `DIR_RESET`, 0, reset value of DIR (1 = output).
- `OUT_RESET`, 0, reset value of DATA_OUT.
- `ALT_RESET`, 'h3, reset value of ALT_SEL. Default routes pins 0/1 to alt function (UART rx/tx).

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
  - `aclk` in 1 — clock.
  - `aresetn` in 1 — synchronous active-low reset.
- Register bus:
  - `reg_wr` in 1 — write strobe.
  - `reg_rd` in 1 — read strobe.
  - `reg_addr` in 3 — word address.
  - `reg_wdata` in 32 — write data.
  - `reg_rdata` out 32 — read data.
  - `reg_ack` out 1 — one-cycle access acknowledge.
- Pad side:
  - `io_i` in N_PINS — pad input.
  - `io_o` out N_PINS — pad output.
  - `io_t` out N_PINS — tristate, 1 = high-Z.
- Alternate function:
  - `alt_o` in N_PINS — peripheral output.
  - `alt_t` in N_PINS — peripheral tristate.
  - `alt_i` out N_PINS — synchronised pad input to peripheral.
- `irq` out 1 — level interrupt.

## Operation
- Register map (word address):
  - 0 DATA_OUT (RW)
  - 1 DIR (RW, 1 = output)
  - 2 DATA_IN (RO)
  - 3 ALT_SEL (RW)
  - 4 RISE_EN (RW)
  - 5 FALL_EN (RW)
  - 6 IRQ_STATUS (RO, W1C)
  - 7 reserved
- Only bits [N_PINS-1:0] are implemented. Upper bits read 0 and writes to them are ignored.
- Reserved address 7: reads return 0, writes are ignored, and `reg_ack` is still pulsed.
- Writes to DATA_IN are ignored. A write to IRQ_STATUS clears each bit written as 1.
- Input path: 3-stage register chain per pin, s1 <= io_i, s2 <= s1, s3 <= s2.
  - DATA_IN = s2.
  - `alt_i` = s2.
- Edge detect per pin:
  - rise = s2 & ~s3.
  - fall = ~s2 & s3.
- IRQ_STATUS[i] update, each clock:
  - set if (rise & RISE_EN[i]) | (fall & FALL_EN[i]);
  - otherwise cleared if a W1C write with bit i set occurs;
  - otherwise held.
  - Set beats clear when both occur in the same cycle.
  - Edges on disabled pins are not recorded. Disabling an enable does not clear an already-set status bit.
- `irq` = OR-reduction of IRQ_STATUS (combinational from the register).
- Pin mux per pin:
  - ALT_SEL[i] = 1: io_o[i] = alt_o[i], io_t[i] = alt_t[i].
  - ALT_SEL[i] = 0: io_o[i] = DATA_OUT[i], io_t[i] = ~DIR[i].
- Edge detection runs regardless of ALT_SEL and DIR. An output pin observes its own driven level.
- Reset (`aresetn` = 0 at a rising edge):
  - DATA_OUT = OUT_RESET, DIR = DIR_RESET, ALT_SEL = ALT_RESET.
  - RISE_EN = FALL_EN = IRQ_STATUS = 0.
  - s1/s2/s3 = 0, `reg_rdata` = 0, `reg_ack` = 0, `irq` = 0.
- Reset mid-access: the pending ack is dropped and no write takes effect.
- The first edge after reset may flag a rise if a pin is high, because s3 = 0. This is harmless: enables are 0 at reset.

## Timing
- Write: `reg_wr` sampled at edge k updates the register at edge k. `reg_ack` is high for the cycle after edge k, and pad outputs change after edge k.
- Read: `reg_rd` sampled at edge k loads `reg_rdata` at edge k, with `reg_ack` high for the cycle after edge k.
  - `reg_rdata` holds its value until the next read.
  - Read data reflects register state before any same-edge update.
- `reg_wr` and `reg_rd` both high: the write is performed, the read is ignored, and one ack is given.
- Back-to-back accesses every cycle are supported; `reg_ack` pulses once per access.
- Input latency, pin change stable before edge 0:
  - s2 (DATA_IN, `alt_i`) updates at edge 1.
  - IRQ_STATUS sets at edge 2.
  - `irq` is high after edge 2.
- Minimum detectable pulse width: 1 cycle, provided it is sampled by s1.

## Test plan
- Reset defaults (N_PINS=14): after reset, io_t = 14'h3FFF with io_t[1:0] following alt_t. Read ALT_SEL -> 3, DIR -> 0, IRQ_STATUS -> 0. `irq` = 0.
- GPIO output: write ALT_SEL=0, DIR=14'h00F0, DATA_OUT=14'h0050 -> io_t = 14'h3F0F and io_o[7:4] = 4'b0101 the cycle after each write ack. Read DATA_OUT -> 32'h50.
- Alt passthrough: ALT_SEL=3, drive alt_o[1]=1, alt_t[1]=0 -> io_o[1]=1, io_t[1]=0 immediately. Toggle io_i[0] -> alt_i[0] follows 2 cycles later.
- Edge IRQ: RISE_EN=14'h0004, FALL_EN=0. Raise io_i[2] -> IRQ_STATUS = 4 and `irq` = 1 after the 3rd edge. Drop io_i[2] -> no change. Raise io_i[3] -> no change.
- W1C race: with IRQ_STATUS = 4, write 4 to addr 6 in the same cycle a new rise on pin 2 sets the bit -> bit remains 1. A later clear write without an edge -> 0, and `irq` deasserts.
- Bus corners: read addr 7 -> 0 with ack. Write 32'hFFFF_FFFF to DIR -> reads 14'h3FFF. Simultaneous rd+wr -> one ack, write applied. Assert `aresetn` low mid-sequence -> all registers back to defaults the next cycle.
